// File: rtl/rand_range_sampler.sv
// -----------------------------------------------------------------------------
// rand_range_sampler
//
// Rejection sampler placed after a small pseudorandom generator. Each valid raw
// sample is tested against the inclusive range [MIN_VAL, MAX_VAL]. In-range
// samples are queued in a DEPTH-entry FIFO and offered downstream over a
// valid/ready handshake. Out-of-range samples are counted as rejects. In-range
// samples that find the FIFO full (and not popping) are counted as drops.
//
// Optional feature: define RAND_SAMPLER_STUCK_EN to build a run-length
// detector that raises the sticky `stuck` flag after STUCK_LEN consecutive
// identical valid samples. Without the macro, `stuck` is tied to 0.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous active-low reset
//   rand_in     raw sample from the generator
//   rand_valid  rand_in is fresh this cycle
//   dout        FIFO head value
//   dout_valid  FIFO not empty
//   dout_ready  consumer accepts dout this cycle
//   level       FIFO occupancy, 0..DEPTH
//   reject_cnt  saturating count of out-of-range samples
//   drop_cnt    saturating count of in-range samples lost to a full FIFO
//   stuck       sticky stuck-generator flag
// -----------------------------------------------------------------------------
module rand_range_sampler #(
  parameter int DATA_W    = 4,
  parameter int MIN_VAL   = 1,
  parameter int MAX_VAL   = 6,
  parameter int DEPTH     = 4,
  parameter int STUCK_LEN = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        rand_in,
  input  logic                     rand_valid,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               reject_cnt,
  output logic [7:0]               drop_cnt,
  output logic                     stuck
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [DATA_W-1:0] LO_VAL   = DATA_W'(MIN_VAL);
  localparam logic [DATA_W-1:0] HI_VAL   = DATA_W'(MAX_VAL);
  localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic in_range;
  logic candidate;
  logic pop;
  logic push;
  logic drop;
  logic reject;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    in_range  = 1'b0;
    candidate = 1'b0;
    reject    = 1'b0;
    if (rand_valid) begin
      in_range  = (rand_in >= LO_VAL) && (rand_in <= HI_VAL);
      candidate = in_range;
      reject    = !in_range;
    end
  end

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign pop        = dout_valid && dout_ready;
  assign push       = candidate && ((level != FULL_LVL) || pop);
  assign drop       = candidate && !push;

  // Both outputs derive from registers only: no path from rand_in or
  // dout_ready reaches them combinationally.
  assign dout_valid = (level != '0);
  assign dout       = mem[rd_ptr];

  // NOTE: the storage array is reset along with the pointers so that dout,
  // which always shows the entry at the read pointer, reads 0 out of reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= rand_in;
        wr_ptr      <= wr_ptr + 1'b1;  // wraps modulo DEPTH
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reject_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (reject && (reject_cnt != 8'hFF)) reject_cnt <= reject_cnt + 8'd1;
      if (drop && (drop_cnt != 8'hFF))     drop_cnt   <= drop_cnt + 8'd1;
    end
  end

`ifdef RAND_SAMPLER_STUCK_EN
  logic [DATA_W-1:0] prev_sample;
  logic [7:0]        run_len;
  logic [7:0]        run_next;

  // run_len == 0 only before the first valid sample after reset, so the
  // reset value of prev_sample is never mistaken for a real previous sample.
  always_comb begin
    run_next = 8'd1;
    if ((run_len != 8'd0) && (rand_in == prev_sample))
      run_next = (run_len == 8'hFF) ? run_len : run_len + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_sample <= '0;
      run_len     <= '0;
      stuck       <= 1'b0;
    end else if (rand_valid) begin
      prev_sample <= rand_in;
      run_len     <= run_next;
      if (run_next >= 8'(STUCK_LEN)) stuck <= 1'b1;
    end
  end
`else
  logic [7:0] unused_stuck_len;
  assign unused_stuck_len = 8'(STUCK_LEN);
  assign stuck            = 1'b0;
`endif

endmodule

// File: tb/tb_rand_range_sampler.sv
// -----------------------------------------------------------------------------
// Bench for rand_range_sampler. A queue-based reference model tracks the
// accepted samples, the counters and the stuck flag from the behavioural
// rules; each scenario task compares DUT outputs against it and against
// directed constants.
// -----------------------------------------------------------------------------
module tb_rand_range_sampler;

  localparam int DATA_W    = 4;
  localparam int MIN_VAL   = 1;
  localparam int MAX_VAL   = 6;
  localparam int DEPTH     = 4;
  localparam int STUCK_LEN = 8;
`ifdef RAND_SAMPLER_STUCK_EN
  localparam bit STUCK_EN = 1'b1;
`else
  localparam bit STUCK_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [DATA_W-1:0]      rand_in;
  logic                   rand_valid;
  logic [DATA_W-1:0]      dout;
  logic                   dout_valid;
  logic                   dout_ready;
  logic [$clog2(DEPTH):0] level;
  logic [7:0]             reject_cnt;
  logic [7:0]             drop_cnt;
  logic                   stuck;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int q[$];
  int m_reject, m_drop, m_run, m_prev;
  bit m_have_prev, m_stuck;

  rand_range_sampler #(
    .DATA_W(DATA_W), .MIN_VAL(MIN_VAL), .MAX_VAL(MAX_VAL),
    .DEPTH(DEPTH), .STUCK_LEN(STUCK_LEN)
  ) dut (
    .clk(clk), .rst(rst), .rand_in(rand_in), .rand_valid(rand_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .level(level), .reject_cnt(reject_cnt), .drop_cnt(drop_cnt),
    .stuck(stuck)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_reject = 0; m_drop = 0; m_run = 0; m_prev = 0;
    m_have_prev = 1'b0; m_stuck = 1'b0;
  endtask

  // One cycle of the behavioural rules, evaluated on pre-edge state.
  task automatic model_step(input int din, input bit vld, input bit rdy);
    bit popping;
    popping = (q.size() != 0) && rdy;
    if (popping) void'(q.pop_front());
    if (vld) begin
      if (din >= MIN_VAL && din <= MAX_VAL) begin
        if (q.size() < DEPTH) q.push_back(din);
        else m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end else begin
        m_reject = (m_reject < 255) ? m_reject + 1 : 255;
      end
      if (m_have_prev && din == m_prev) m_run++;
      else m_run = 1;
      m_prev = din;
      m_have_prev = 1'b1;
      if (STUCK_EN && m_run >= STUCK_LEN) m_stuck = 1'b1;
    end
  endtask

  // Drive one cycle of stimulus, advance the model, sample #1 after the edge.
  task automatic step(input int din, input bit vld, input bit rdy);
    @(negedge clk);
    rand_in    = DATA_W'(din);
    rand_valid = vld;
    dout_ready = rdy;
    model_step(din, vld, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; rand_valid = 1'b0; dout_ready = 1'b0; rand_in = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) step(2 + i, 1'b1, 1'b0);
    checks++;
    if (level !== 3) begin
      errors++; $display("FAIL reset_prefill_level: got %0d expected 3", level);
    end
    // Assert reset mid-cycle, away from any clock edge.
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (level !== 0 || dout_valid !== 1'b0 || dout !== 0 || reject_cnt !== 0 ||
        drop_cnt !== 0 || stuck !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got level=%0d valid=%b dout=%0d rej=%0d drop=%0d stuck=%b expected all 0",
               level, dout_valid, dout, reject_cnt, drop_cnt, stuck);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(5, 1'b0, 1'b1);
    checks++;
    if (level !== 0 || dout_valid !== 1'b0 || dout !== 0 || reject_cnt !== 0 ||
        drop_cnt !== 0 || stuck !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got level=%0d valid=%b dout=%0d rej=%0d drop=%0d stuck=%b expected all 0",
               level, dout_valid, dout, reject_cnt, drop_cnt, stuck);
    end
  endtask

  task automatic test_filtering();
    int in_seq[6]    = '{0, 3, 7, 6, 15, 1};
    bit exp_vld[6]   = '{0, 1, 0, 1, 0, 1};
    int exp_dout[6]  = '{0, 3, 0, 6, 0, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(in_seq[i], 1'b1, 1'b1);
      checks++;
      if (dout_valid !== exp_vld[i] || (exp_vld[i] && dout !== exp_dout[i])) begin
        errors++;
        $display("FAIL filter_out[%0d]: got valid=%b dout=%0d expected valid=%b dout=%0d",
                 i, dout_valid, dout, exp_vld[i], exp_dout[i]);
      end
    end
    checks++;
    if (reject_cnt !== 3 || reject_cnt !== m_reject) begin
      errors++; $display("FAIL filter_reject_cnt: got %0d expected 3", reject_cnt);
    end
  endtask

  task automatic test_backpressure();
    int in_seq[6]  = '{2, 3, 4, 5, 1, 2};
    int exp_pop[4] = '{2, 3, 4, 5};
    do_reset();
    for (int i = 0; i < 6; i++) step(in_seq[i], 1'b1, 1'b0);
    checks++;
    if (level !== 4 || drop_cnt !== 2) begin
      errors++; $display("FAIL bp_full: got level=%0d drop=%0d expected level=4 drop=2", level, drop_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== exp_pop[i]) begin
        errors++;
        $display("FAIL bp_pop[%0d]: got valid=%b dout=%0d expected valid=1 dout=%0d",
                 i, dout_valid, dout, exp_pop[i]);
      end
      step(0, 1'b0, 1'b1);
    end
    checks++;
    if (dout_valid !== 1'b0 || level !== 0) begin
      errors++; $display("FAIL bp_drained: got valid=%b level=%0d expected 0 0", dout_valid, level);
    end
  endtask

  task automatic test_pass_through();
    int exp_pop[4] = '{3, 4, 5, 6};
    do_reset();
    for (int i = 0; i < 4; i++) step(2 + i, 1'b1, 1'b0);
    step(6, 1'b1, 1'b1);
    checks++;
    if (level !== 4 || drop_cnt !== 0 || dout !== 3) begin
      errors++;
      $display("FAIL pass_through: got level=%0d drop=%0d dout=%0d expected 4 0 3", level, drop_cnt, dout);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== exp_pop[i]) begin
        errors++;
        $display("FAIL pass_pop[%0d]: got valid=%b dout=%0d expected valid=1 dout=%0d",
                 i, dout_valid, dout, exp_pop[i]);
      end
      step(0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) step(0, 1'b1, 1'b1);
    checks++;
    if (reject_cnt !== 255) begin
      errors++; $display("FAIL reject_saturate: got %0d expected 255", reject_cnt);
    end
    // Drop counter saturation: full FIFO, no pops, 300 in-range samples.
    do_reset();
    for (int i = 0; i < 300; i++) step(4, 1'b1, 1'b0);
    checks++;
    if (drop_cnt !== 255 || level !== 4) begin
      errors++; $display("FAIL drop_saturate: got drop=%0d level=%0d expected 255 4", drop_cnt, level);
    end
  endtask

  task automatic test_stuck();
    do_reset();
    for (int i = 0; i < 7; i++) step(0, 1'b1, 1'b1);
    // An idle cycle must not advance the run.
    step(0, 1'b0, 1'b1);
    checks++;
    if (stuck !== 1'b0) begin
      errors++; $display("FAIL stuck_seven: got %b expected 0", stuck);
    end
    step(0, 1'b1, 1'b1);
    checks++;
    if (stuck !== STUCK_EN || stuck !== m_stuck) begin
      errors++; $display("FAIL stuck_eighth: got %b expected %b", stuck, STUCK_EN);
    end
    for (int i = 0; i < 6; i++) step(i + 1, 1'b1, 1'b1);
    checks++;
    if (stuck !== STUCK_EN) begin
      errors++; $display("FAIL stuck_sticky: got %b expected %b", stuck, STUCK_EN);
    end
    // A broken run of 7 followed by a fresh run must not trip early.
    do_reset();
    for (int i = 0; i < 7; i++) step(9, 1'b1, 1'b1);
    step(8, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(8, 1'b1, 1'b1);
    checks++;
    if (stuck !== STUCK_EN) begin
      errors++; $display("FAIL stuck_rerun: got %b expected %b", stuck, STUCK_EN);
    end
  endtask

  task automatic test_random();
    int din;
    bit vld, rdy;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      // Bias toward repeats so runs and full/empty boundaries both occur.
      din = ($urandom_range(0, 3) == 0) ? m_prev : int'($urandom_range(0, 15));
      vld = ($urandom_range(0, 4) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      step(din, vld, rdy);
      checks++;
      if (level !== q.size() || dout_valid !== (q.size() != 0) ||
          (q.size() != 0 && dout !== q[0]) || reject_cnt !== m_reject ||
          drop_cnt !== m_drop || stuck !== m_stuck) begin
        errors++;
        $display("FAIL random[%0d]: got level=%0d valid=%b dout=%0d rej=%0d drop=%0d stuck=%b expected level=%0d head=%0d rej=%0d drop=%0d stuck=%b",
                 i, level, dout_valid, dout, reject_cnt, drop_cnt, stuck,
                 q.size(), (q.size() != 0) ? q[0] : 0, m_reject, m_drop, m_stuck);
      end
    end
  endtask

  initial begin
    rst = 1'b0; rand_in = '0; rand_valid = 1'b0; dout_ready = 1'b0;
    model_reset();
    test_reset();
    test_filtering();
    test_backpressure();
    test_pass_through();
    test_saturation();
    test_stuck();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
